gpio_irq_ctrl: RTL
==================

GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 32, number of GPIO input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, stable-input cycles required by the debounce filter (1..255).
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port gpio_in  input  NUM_CH  raw asynchronous pad inputs.
REQ-007 Port irq_en_i  input  NUM_CH  per-channel interrupt enable.
REQ-008 Port irq_mode_i  input  2*NUM_CH  per-channel mode: 0 rise, 1 fall, 2 both edges, 3 level-high.
REQ-009 Port irq_valid_o  output  1  an enabled pending event exists.
REQ-010 Port irq_id_o  output  5  index of the granted channel, valid while irq_valid_o is high.
REQ-011 Port irq_ready_i  input  1  consumer accepts the presented event.
REQ-012 Port pending_o  output  NUM_CH  raw pending register.
REQ-013 Port overrun_o  output  NUM_CH  sticky: event arrived while the channel was already pending.
REQ-014 Port overrun_clr_i  input  NUM_CH  one-cycle pulse per bit, clears overrun_o bits.

Function
REQ-015 Each gpio_in bit shall pass through SYNC_STAGES flops; an edge is the synchronized value differing from its one-cycle-delayed copy.
REQ-016 Events: rise = 0->1, fall = 1->0, both = either, level = synchronized value is 1 on any cycle.
REQ-017 A detected event on a channel with irq_en_i set shall set pending[ch] on the next clock edge; events on disabled channels shall be dropped, not stored.
REQ-018 Clearing irq_en_i shall not clear pending[ch]; a pending but disabled channel shall be masked from arbitration.
REQ-019 irq_valid_o shall be combinational OR of (pending & irq_en_i); irq_id_o shall be the lowest-index such channel (fixed priority), 0 when irq_valid_o is low.
REQ-020 On irq_valid_o && irq_ready_i, pending[irq_id_o] shall clear on that clock edge; one event shall be retired per cycle at most.
REQ-021 Same-cycle set and retire on one channel: set wins, pending stays 1, overrun not flagged.
REQ-022 Event on an already-pending channel (not being retired) shall set overrun[ch]; set wins over same-cycle overrun_clr_i.
REQ-023 Level mode shall not flag overrun; after retire with the level still high, pending shall re-set on the next cycle.
REQ-024 Latency, no debounce: a gpio_in change set up before clock edge k shall raise irq_valid_o after edge k+SYNC_STAGES (3 edges with SYNC_STAGES=2).
REQ-025 irq_mode_i changes shall take effect on the next cycle without creating a spurious event.

Reset
REQ-026 On rst_n low: sync chain, delayed copy, pending, overrun, debounce counters and arm counter shall be 0; irq_valid_o 0, irq_id_o 0.
REQ-027 After reset release, edge and level detection shall be suppressed for SYNC_STAGES+1 cycles (arm counter) so inputs high at reset produce no event.
REQ-028 Reset asserted mid-operation shall discard all pending and overrun state immediately.

Configuration
REQ-029 Macro GPIO_IRQ_DEBOUNCE_EN defined: the synchronized value shall be replaced by a filtered value that changes only after the new level is stable for DEBOUNCE_CYCLES consecutive cycles; latency grows by DEBOUNCE_CYCLES.
REQ-030 Macro undefined: no filter, no counters, DEBOUNCE_CYCLES ignored, latency per REQ-024.

Structure
REQ-031 Package gpio_irq_pkg shall hold the mode enum (IRQ_RISE, IRQ_FALL, IRQ_BOTH, IRQ_LEVEL) and the ID width constant 5.
REQ-032 Sub-module gpio_irq_sync shall implement one channel's synchronizer, optional debounce and delayed copy; instantiated NUM_CH times by generate.

Verification
REQ-033 ch1 rise mode enabled, gpio_in[1] 0->1 -> irq_valid_o high 3 cycles later, irq_id_o=1; ready pulse -> pending_o[1]=0 next cycle.
REQ-034 ch1 and ch2 rise at once, ready held high -> id 1 then id 2 on consecutive cycles, then valid low.
REQ-035 ch2 level mode, gpio_in[2] held high, ready held high -> valid stays high, id=2 each cycle, overrun_o[2]=0.
REQ-036 ch1 both mode, toggle gpio_in[1] twice with ready low -> pending_o[1]=1, overrun_o[1]=1; overrun_clr_i[1] pulse -> overrun_o[1]=0.
REQ-037 gpio_in=32'hFFFF_FFFF during and after reset, all channels rise mode enabled -> irq_valid_o never asserts.
REQ-038 GPIO_IRQ_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle glitch on gpio_in[3] -> no event; 6-cycle pulse -> one event, id=3.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared types and constants for the GPIO interrupt controller.
//   irq_mode_e  - per-channel trigger mode (rise, fall, both edges, level-high)
//   IRQ_ID_W    - width of the granted channel index
//   mode_event  - decodes one channel's event from its current/previous level
package gpio_irq_pkg;

  localparam int unsigned IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    IRQ_RISE  = 2'd0,
    IRQ_FALL  = 2'd1,
    IRQ_BOTH  = 2'd2,
    IRQ_LEVEL = 2'd3
  } irq_mode_e;

  // cur is the conditioned level this cycle, prev is its one-cycle-delayed copy.
  function automatic logic mode_event(irq_mode_e mode, logic cur, logic prev);
    logic evt;
    evt = 1'b0;
    unique case (mode)
      IRQ_RISE:  evt = cur & ~prev;
      IRQ_FALL:  evt = ~cur & prev;
      IRQ_BOTH:  evt = cur ^ prev;
      IRQ_LEVEL: evt = cur;
      default:   evt = 1'b0;
    endcase
    return evt;
  endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// gpio_irq_ctrl_if: valid/ready event handshake between the controller and its consumer.
//   irq_valid_o - an enabled pending event is presented
//   irq_id_o    - index of the presented channel
//   irq_ready_i - consumer accepts the presented event this cycle
// master: the controller side; slave: the consumer side.
interface gpio_irq_ctrl_if;
  import gpio_irq_pkg::*;

  logic                irq_valid_o;
  logic [IRQ_ID_W-1:0] irq_id_o;
  logic                irq_ready_i;

  modport master (
    output irq_valid_o,
    output irq_id_o,
    input  irq_ready_i
  );

  modport slave (
    input  irq_valid_o,
    input  irq_id_o,
    output irq_ready_i
  );

endinterface

// File: rtl/gpio_irq_sync.sv
// gpio_irq_sync: conditions one raw pad input for edge/level detection.
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN (adds a stability filter).
//   clk, rst_n - clock and asynchronous active-low reset
//   pin        - raw asynchronous pad input
//   level      - synchronized (and, with the filter, debounced) level
//   level_q    - level delayed by one cycle, used for edge detection
module gpio_irq_sync #(
  parameter int unsigned SYNC_STAGES     = 2
`ifdef GPIO_IRQ_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic level_q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   synced;
  logic                   cond;
  logic                   delay_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign synced = chain_q[SYNC_STAGES-1];

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic       filt_q;
  logic [7:0] cnt_q;

  // The filtered level follows the synchronizer only once it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any return to agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (synced == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == 8'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= synced;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 8'd1;
    end
  end

  assign cond = filt_q;
`else
  assign cond = synced;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= 1'b0;
    end else begin
      delay_q <= cond;
    end
  end

  assign level   = cond;
  assign level_q = delay_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl: per-channel GPIO edge/level interrupt capture with fixed-priority
// presentation of one pending event per cycle over a valid/ready handshake.
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN (debounce filter in each channel).
//   clk, rst_n     - clock and asynchronous active-low reset
//   gpio_in        - raw asynchronous pad inputs
//   irq_en_i       - per-channel interrupt enable
//   irq_mode_i     - 2 bits per channel, see gpio_irq_pkg::irq_mode_e
//   pending_o      - raw pending register (not masked by enable)
//   overrun_o      - sticky: event arrived while the channel was already pending
//   overrun_clr_i  - per-bit pulse clearing overrun_o
//   irq_if         - master side of the event handshake (valid, id, ready)
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_CH          = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     gpio_in,
  input  logic [NUM_CH-1:0]     irq_en_i,
  input  logic [2*NUM_CH-1:0]   irq_mode_i,
  output logic [NUM_CH-1:0]     pending_o,
  output logic [NUM_CH-1:0]     overrun_o,
  input  logic [NUM_CH-1:0]     overrun_clr_i,
  gpio_irq_ctrl_if.master       irq_if
);

  // Detection stays off until the synchronizer (and filter, when present) and the
  // delayed copy have settled, so a pad already high at reset yields no event.
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int unsigned ArmCycles = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
  localparam int unsigned ArmCycles = SYNC_STAGES + 1;
`endif
  localparam int unsigned ArmW = $clog2(ArmCycles + 1);

  logic [ArmW-1:0]     arm_q;
  logic                armed;

  logic [NUM_CH-1:0]   lvl;
  logic [NUM_CH-1:0]   lvl_q;
  logic [NUM_CH-1:0]   evt;
  logic [NUM_CH-1:0]   lvl_mode;
  logic [NUM_CH-1:0]   set;
  logic [NUM_CH-1:0]   active;
  logic [NUM_CH-1:0]   grant_oh;
  logic [IRQ_ID_W-1:0] grant_id;
  logic                found;
  logic                valid;
  logic [NUM_CH-1:0]   retire;

  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   overrun_q, overrun_d;

  // Per-channel conditioning
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef GPIO_IRQ_DEBOUNCE_EN
    gpio_irq_sync #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin     (gpio_in[g]),
      .level   (lvl[g]),
      .level_q (lvl_q[g])
    );
`else
    gpio_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin     (gpio_in[g]),
      .level   (lvl[g]),
      .level_q (lvl_q[g])
    );
`endif
  end

  // Arm counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= '0;
    end else if (arm_q != ArmW'(ArmCycles)) begin
      arm_q <= arm_q + 1'b1;
    end
  end

  assign armed = (arm_q == ArmW'(ArmCycles));

  // Event decode; mode is read combinationally each cycle and history lives only in
  // the level/delayed-level pair, so a mode change cannot fabricate an edge.
  always_comb begin
    evt      = '0;
    lvl_mode = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      lvl_mode[i] = (irq_mode_i[2*i +: 2] == IRQ_LEVEL);
      evt[i]      = armed & mode_event(irq_mode_e'(irq_mode_i[2*i +: 2]), lvl[i], lvl_q[i]);
    end
  end

  // Disabled channels drop their events instead of storing them.
  assign set    = evt & irq_en_i;
  assign active = pending_q & irq_en_i;

  // Fixed priority: lowest index wins.
  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && active[i]) begin
        found       = 1'b1;
        grant_oh[i] = 1'b1;
        grant_id    = IRQ_ID_W'(i);
      end
    end
  end

  assign valid  = |active;
  assign retire = (valid && irq_if.irq_ready_i) ? grant_oh : '0;

  // A same-cycle set beats retire, and a same-cycle overrun beats its clear. An event
  // meeting a pending bit that is being retired is a fresh capture, not an overrun.
  // Level mode re-asserts every cycle by design, so it never counts as an overrun.
  always_comb begin
    pending_d = (pending_q & ~retire) | set;
    overrun_d = (overrun_q & ~overrun_clr_i) | (set & pending_q & ~retire & ~lvl_mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq_if.irq_valid_o = valid;
  assign irq_if.irq_id_o    = grant_id;
  assign pending_o          = pending_q;
  assign overrun_o          = overrun_q;

endmodule
